// File: rtl/psum_acc_reader.sv
// Fetches NUM_KIJ partial sums per output position from the psum SRAM, accumulates them per lane and applies optional ReLU.
// The first result is valid NUM_KIJ+2 cycles after start. While out_ready is low the result is held and no reads are issued.
module psum_acc_reader #(
  parameter int psum_bw   = 16,
  parameter int col       = 8,
  parameter int NUM_KIJ   = 9,
  parameter int NUM_OUT   = 36,
  parameter int ADD_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [ADD_WIDTH-1:0]     sram_addr,
  input  logic [psum_bw*col-1:0]   sram_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [psum_bw*col-1:0]   sfp_out
);

  localparam int KW = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int DW = psum_bw * col;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [KW-1:0]        kij_q, kij_d;
  logic [OW-1:0]        onij_q, onij_d;
  logic [ADD_WIDTH-1:0] base_q, base_d;
  logic                 relu_q, relu_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 rd_first_q, rd_first_d;
  logic [DW-1:0]        acc_q, acc_d;

  always_comb begin
    state_d    = state_q;
    kij_d      = kij_q;
    onij_d     = onij_q;
    base_d     = base_q;
    relu_d     = relu_q;
    // Read data returns one cycle after issue; remember whether it starts a new sum.
    rd_vld_d   = (state_q == S_READ);
    rd_first_d = (kij_q == '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          onij_d  = '0;
          kij_d   = '0;
          base_d  = '0;
          relu_d  = relu_en;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (kij_q == KW'(NUM_KIJ - 1)) begin
          state_d = S_LAST;
        end else begin
          kij_d  = kij_q + KW'(1);
          base_d = base_q + ADD_WIDTH'(NUM_OUT);
        end
      end
      S_LAST: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (onij_q == OW'(NUM_OUT - 1)) begin
            state_d = S_DONE;
          end else begin
            onij_d  = onij_q + OW'(1);
            kij_d   = '0;
            base_d  = '0;
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (rd_vld_q) begin
      for (int c = 0; c < col; c++) begin
        acc_d[psum_bw*c +: psum_bw] = sram_q[psum_bw*c +: psum_bw] +
            (rd_first_q ? {psum_bw{1'b0}} : acc_q[psum_bw*c +: psum_bw]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kij_q      <= '0;
      onij_q     <= '0;
      base_q     <= '0;
      relu_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      kij_q      <= kij_d;
      onij_q     <= onij_d;
      base_q     <= base_d;
      relu_q     <= relu_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
      acc_q      <= acc_d;
    end
  end

  always_comb begin
    sfp_out = acc_q;
    for (int c = 0; c < col; c++) begin
      if (relu_q && acc_q[psum_bw*c + psum_bw - 1]) begin
        sfp_out[psum_bw*c +: psum_bw] = {psum_bw{1'b0}};
      end
    end
  end

  assign busy      = (state_q == S_READ) || (state_q == S_LAST) || (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_OUT);
  assign sram_cen  = (state_q != S_READ);
  assign sram_wen  = 1'b1;
  assign sram_addr = (state_q == S_READ) ? (base_q + ADD_WIDTH'(onij_q)) : '0;

endmodule

// File: tb/tb_psum_acc_reader.sv
// Randomised and directed bench for psum_acc_reader: SRAM model, scoreboard queues and an independent monitor.
module tb_psum_acc_reader;
  localparam int PB = 16, COL = 8, NK = 9, NO = 36, AW = 11, W = PB * COL;

  logic          clk = 1'b0;
  logic          reset, start, relu_en, out_ready;
  logic          busy, done, sram_cen, sram_wen, out_valid;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_q = '0;
  logic [W-1:0]  sfp_out;

  logic [W-1:0]  mem [NK*NO];
  logic [W-1:0]  exp_q [$];
  int            addr_q [$];
  int            compared = 0, mismatched = 0, hs_cnt = 0, done_cnt = 0;
  int            rdy_mode = 0;

  always #5 clk = ~clk;

  psum_acc_reader #(.psum_bw(PB), .col(COL), .NUM_KIJ(NK), .NUM_OUT(NO), .ADD_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_q(sram_q),
    .out_valid(out_valid), .out_ready(out_ready), .sfp_out(sfp_out));

  always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_addr];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT shows a handshake or a read.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_output: got %h expected none", sfp_out);
        end else check("sfp_out", sfp_out, exp_q.pop_front());
      end
      if (!sram_cen) begin
        if (addr_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_read: got addr %0d expected none", sram_addr);
        end else check("sram_addr", W'(sram_addr), addr_q.pop_front());
        check("sram_wen", W'(sram_wen), 1);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: signed sum over kernel positions, wrapped to PB bits, then ReLU.
  function automatic logic [W-1:0] model_out(int onij, bit relu);
    logic [W-1:0]  r;
    logic [PB-1:0] lane;
    int            sum;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      sum = 0;
      for (int k = 0; k < NK; k++) begin
        lane = mem[k*NO + onij][PB*c +: PB];
        sum  = sum + int'($signed(lane));
      end
      lane = PB'(sum);
      if (relu && $signed(lane) < 0) lane = '0;
      r[PB*c +: PB] = lane;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] basic_out();
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[PB*c +: PB] = PB'(36 + 9*c);
    return r;
  endfunction

  task automatic push_addrs();
    for (int o = 0; o < NO; o++)
      for (int k = 0; k < NK; k++) addr_q.push_back(k*NO + o);
  endtask

  task automatic pulse_start(input bit relu);
    @(negedge clk); relu_en = relu; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_pass(input bit relu, input bit inject, output int cyc);
    int hs0, d0;
    push_addrs();
    hs0 = hs_cnt; d0 = done_cnt;
    pulse_start(relu);
    cyc = 1;
    while (!done && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (inject) begin
        if (cyc == 3 || cyc == 11) start = 1'b1;
        if (cyc == 4 || cyc == 12) start = 1'b0;
        if (cyc == 5) relu_en = ~relu;
      end
    end
    check("done_seen", W'(done), 1);
    check("busy_at_done", W'(busy), 0);
    @(negedge clk);
    check("done_single_pulse", W'(done), 0);
    check("done_count", W'(done_cnt - d0), 1);
    check("handshake_count", W'(hs_cnt - hs0), 36);
    check("exp_queue_drained", W'(exp_q.size()), 0);
    check("addr_queue_drained", W'(addr_q.size()), 0);
  endtask

  initial begin
    int cyc, n;
    logic [W-1:0] v;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_cen", W'(sram_cen), 1);
    check("rst_wen", W'(sram_wen), 1);
    check("rst_addr", W'(sram_addr), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_sfp_out", sfp_out, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cen", W'(sram_cen), 1);

    // Basic: lane c of psum[kij][onij] = kij + c.
    for (int k = 0; k < NK; k++)
      for (int o = 0; o < NO; o++)
        for (int c = 0; c < COL; c++) mem[k*NO + o][PB*c +: PB] = PB'(k + c);
    for (int o = 0; o < NO; o++) exp_q.push_back(basic_out());
    run_pass(1'b0, 1'b0, cyc);
    check("basic_start_to_done", W'(cyc), 397);

    // Stray start pulses during READ and OUT must not disturb the pass.
    for (int o = 0; o < NO; o++) exp_q.push_back(basic_out());
    run_pass(1'b0, 1'b1, cyc);
    check("ignored_start_to_done", W'(cyc), 397);

    // Backpressure at onij=0.
    for (int o = 0; o < NO; o++) exp_q.push_back(basic_out());
    push_addrs();
    rdy_mode = 2;
    @(negedge clk); out_ready = 1'b0;
    pulse_start(1'b0);
    n = 1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_first_valid_cycle", W'(n), 11);
    v = basic_out();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), 1);
      check("bp_sfp_stable", sfp_out, v);
      check("bp_cen_idle", W'(sram_cen), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    check("bp_next_valid_latency", W'(n), 11);
    rdy_mode = 0;
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    check("bp_done_seen", W'(done), 1);
    @(negedge clk);
    check("bp_exp_drained", W'(exp_q.size()), 0);

    // Reset during READ of onij=3, then a clean restart.
    for (int o = 0; o < NO; o++) exp_q.push_back(basic_out());
    push_addrs();
    pulse_start(1'b0);
    cyc = 1;
    while (cyc < 36) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", W'(busy), 0);
    check("midrst_cen", W'(sram_cen), 1);
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_done", W'(done), 0);
    check("midrst_sfp_out", sfp_out, 0);
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    for (int o = 0; o < NO; o++) exp_q.push_back(basic_out());
    run_pass(1'b0, 1'b0, cyc);
    check("restart_start_to_done", W'(cyc), 397);

    // Signed wrap and ReLU: lane0 = -3, lane1 = 0x7000, other lanes 0.
    for (int i = 0; i < NK*NO; i++) begin
      mem[i] = '0;
      mem[i][PB*0 +: PB] = 16'hFFFD;
      mem[i][PB*1 +: PB] = 16'h7000;
    end
    for (int o = 0; o < NO; o++) exp_q.push_back('0);
    run_pass(1'b1, 1'b1, cyc);
    v = '0;
    v[PB*0 +: PB] = 16'hFFE5;
    v[PB*1 +: PB] = 16'hF000;
    for (int o = 0; o < NO; o++) exp_q.push_back(v);
    run_pass(1'b0, 1'b0, cyc);

    // Random data, random ReLU, random backpressure.
    for (int t = 0; t < 3; t++) begin
      bit r;
      for (int i = 0; i < NK*NO; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      r = 1'($urandom_range(0, 1));
      for (int o = 0; o < NO; o++) exp_q.push_back(model_out(o, r));
      rdy_mode = 1;
      run_pass(r, 1'b0, cyc);
      rdy_mode = 0;
      check("rand_min_duration", W'(cyc >= 397), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
